// File: rtl/ps2_pkg.sv
// Shared constants, state encoding and held-key payload for the PS/2 Set 2 keyboard decoder.
package ps2_pkg;

  localparam int unsigned SCAN_W = 8;
  localparam int unsigned KEY_W  = 16;

  localparam logic [SCAN_W-1:0] SC_E0     = 8'hE0;
  localparam logic [SCAN_W-1:0] SC_F0     = 8'hF0;
  localparam logic [SCAN_W-1:0] SC_E1     = 8'hE1;
  localparam logic [SCAN_W-1:0] SC_LSHIFT = 8'h12;
  localparam logic [SCAN_W-1:0] SC_RSHIFT = 8'h59;

  localparam logic [7:0] HK_ENTER = 8'd128;
  localparam logic [7:0] HK_BKSP  = 8'd129;
  localparam logic [7:0] HK_LEFT  = 8'd130;
  localparam logic [7:0] HK_UP    = 8'd131;
  localparam logic [7:0] HK_RIGHT = 8'd132;
  localparam logic [7:0] HK_DOWN  = 8'd133;
  localparam logic [7:0] HK_HOME  = 8'd134;
  localparam logic [7:0] HK_END   = 8'd135;
  localparam logic [7:0] HK_PGUP  = 8'd136;
  localparam logic [7:0] HK_PGDN  = 8'd137;
  localparam logic [7:0] HK_INS   = 8'd138;
  localparam logic [7:0] HK_DEL   = 8'd139;
  localparam logic [7:0] HK_ESC   = 8'd140;
  localparam logic [7:0] HK_F1    = 8'd141;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK,
    ST_SKIP
  } state_t;

  typedef struct packed {
    logic              ext;
    logic [SCAN_W-1:0] scan;
  } held_t;

  // Same code for shifted and unshifted (non-printable keys).
  function automatic logic [15:0] both(input logic [7:0] c);
    return {c, c};
  endfunction

endpackage

// File: rtl/scancode_to_hack.sv
// Combinational Set 2 scan code to Hack key code table; valid=0 for unmapped keys.
module scancode_to_hack
  import ps2_pkg::*;
(
  input  logic              ext,
  input  logic [SCAN_W-1:0] scan,
  input  logic              shift,
  output logic [KEY_W-1:0]  code,
  output logic              valid
);

  logic [7:0] w_lo;
  logic [7:0] w_hi;

  // {w_lo, w_hi} = {unshifted, shifted} code; zero means unmapped.
  always_comb begin
    w_lo = '0;
    w_hi = '0;
    if (ext) begin
      case (scan)
        8'h6B:   {w_lo, w_hi} = both(HK_LEFT);
        8'h75:   {w_lo, w_hi} = both(HK_UP);
        8'h74:   {w_lo, w_hi} = both(HK_RIGHT);
        8'h72:   {w_lo, w_hi} = both(HK_DOWN);
        8'h6C:   {w_lo, w_hi} = both(HK_HOME);
        8'h69:   {w_lo, w_hi} = both(HK_END);
        8'h7D:   {w_lo, w_hi} = both(HK_PGUP);
        8'h7A:   {w_lo, w_hi} = both(HK_PGDN);
        8'h70:   {w_lo, w_hi} = both(HK_INS);
        8'h71:   {w_lo, w_hi} = both(HK_DEL);
        8'h5A:   {w_lo, w_hi} = both(HK_ENTER);
        default: {w_lo, w_hi} = 16'h0000;
      endcase
    end else begin
      case (scan)
        8'h1C: {w_lo, w_hi} = 16'h6141;  8'h32: {w_lo, w_hi} = 16'h6242;
        8'h21: {w_lo, w_hi} = 16'h6343;  8'h23: {w_lo, w_hi} = 16'h6444;
        8'h24: {w_lo, w_hi} = 16'h6545;  8'h2B: {w_lo, w_hi} = 16'h6646;
        8'h34: {w_lo, w_hi} = 16'h6747;  8'h33: {w_lo, w_hi} = 16'h6848;
        8'h43: {w_lo, w_hi} = 16'h6949;  8'h3B: {w_lo, w_hi} = 16'h6A4A;
        8'h42: {w_lo, w_hi} = 16'h6B4B;  8'h4B: {w_lo, w_hi} = 16'h6C4C;
        8'h3A: {w_lo, w_hi} = 16'h6D4D;  8'h31: {w_lo, w_hi} = 16'h6E4E;
        8'h44: {w_lo, w_hi} = 16'h6F4F;  8'h4D: {w_lo, w_hi} = 16'h7050;
        8'h15: {w_lo, w_hi} = 16'h7151;  8'h2D: {w_lo, w_hi} = 16'h7252;
        8'h1B: {w_lo, w_hi} = 16'h7353;  8'h2C: {w_lo, w_hi} = 16'h7454;
        8'h3C: {w_lo, w_hi} = 16'h7555;  8'h2A: {w_lo, w_hi} = 16'h7656;
        8'h1D: {w_lo, w_hi} = 16'h7757;  8'h22: {w_lo, w_hi} = 16'h7858;
        8'h35: {w_lo, w_hi} = 16'h7959;  8'h1A: {w_lo, w_hi} = 16'h7A5A;
        8'h16: {w_lo, w_hi} = 16'h3121;  8'h1E: {w_lo, w_hi} = 16'h3240;
        8'h26: {w_lo, w_hi} = 16'h3323;  8'h25: {w_lo, w_hi} = 16'h3424;
        8'h2E: {w_lo, w_hi} = 16'h3525;  8'h36: {w_lo, w_hi} = 16'h365E;
        8'h3D: {w_lo, w_hi} = 16'h3726;  8'h3E: {w_lo, w_hi} = 16'h382A;
        8'h46: {w_lo, w_hi} = 16'h3928;  8'h45: {w_lo, w_hi} = 16'h3029;
        8'h0E: {w_lo, w_hi} = 16'h607E;  8'h4E: {w_lo, w_hi} = 16'h2D5F;
        8'h55: {w_lo, w_hi} = 16'h3D2B;  8'h54: {w_lo, w_hi} = 16'h5B7B;
        8'h5B: {w_lo, w_hi} = 16'h5D7D;  8'h5D: {w_lo, w_hi} = 16'h5C7C;
        8'h4C: {w_lo, w_hi} = 16'h3B3A;  8'h52: {w_lo, w_hi} = 16'h2722;
        8'h41: {w_lo, w_hi} = 16'h2C3C;  8'h49: {w_lo, w_hi} = 16'h2E3E;
        8'h4A: {w_lo, w_hi} = 16'h2F3F;  8'h29: {w_lo, w_hi} = 16'h2020;
        8'h5A: {w_lo, w_hi} = both(HK_ENTER);
        8'h66: {w_lo, w_hi} = both(HK_BKSP);
        8'h76: {w_lo, w_hi} = both(HK_ESC);
        8'h05: {w_lo, w_hi} = both(HK_F1);
        8'h06: {w_lo, w_hi} = both(HK_F1 + 8'd1);
        8'h04: {w_lo, w_hi} = both(HK_F1 + 8'd2);
        8'h0C: {w_lo, w_hi} = both(HK_F1 + 8'd3);
        8'h03: {w_lo, w_hi} = both(HK_F1 + 8'd4);
        8'h0B: {w_lo, w_hi} = both(HK_F1 + 8'd5);
        8'h83: {w_lo, w_hi} = both(HK_F1 + 8'd6);
        8'h0A: {w_lo, w_hi} = both(HK_F1 + 8'd7);
        8'h01: {w_lo, w_hi} = both(HK_F1 + 8'd8);
        8'h09: {w_lo, w_hi} = both(HK_F1 + 8'd9);
        8'h78: {w_lo, w_hi} = both(HK_F1 + 8'd10);
        8'h07: {w_lo, w_hi} = both(HK_F1 + 8'd11);
        default: {w_lo, w_hi} = 16'h0000;
      endcase
    end
  end

  assign code  = KEY_W'(shift ? w_hi : w_lo);
  assign valid = (w_lo != 8'h00);

endmodule

// File: rtl/ps2_keyboard_decoder.sv
// PS/2 Set 2 byte stream to Hack KBD register: tracks E0/F0/E1 prefixes, shift keys and the held key.
module ps2_keyboard_decoder
  import ps2_pkg::*;
#(
  parameter int unsigned PAUSE_SKIP = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [SCAN_W-1:0] in_data,
  input  logic              in_ready,
  output logic [KEY_W-1:0]  keycode,
  output logic              key_event,
  output logic              shift
);

  localparam int unsigned SKIP_W = (PAUSE_SKIP > 1) ? $clog2(PAUSE_SKIP + 1) : 1;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_ready_q;
  logic [SKIP_W-1:0]  r_skip_cnt;
  logic [SKIP_W-1:0]  w_skip_nxt;
  held_t              r_held;
  held_t              w_held_nxt;
  logic               r_lshift;
  logic               r_rshift;
  logic               w_lshift_nxt;
  logic               w_rshift_nxt;
  logic [KEY_W-1:0]   w_keycode_nxt;
  logic               w_event_nxt;
  logic               w_stb;
  logic               w_ext;
  logic               w_make;
  logic               w_break;
  logic [KEY_W-1:0]   w_map_code;
  logic               w_map_valid;

  // A ready level already high at reset release is not treated as a new byte.
  assign w_stb = in_ready & ~r_ready_q;
  assign w_ext = (r_state == ST_EXT) || (r_state == ST_EXT_BRK);

  scancode_to_hack u_map (
    .ext   (w_ext),
    .scan  (in_data),
    .shift (shift),
    .code  (w_map_code),
    .valid (w_map_valid)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_skip_nxt  = r_skip_cnt;
    w_make      = 1'b0;
    w_break     = 1'b0;
    if (w_stb) begin
      case (r_state)
        ST_IDLE: begin
          if (in_data == SC_E0)      w_state_nxt = ST_EXT;
          else if (in_data == SC_F0) w_state_nxt = ST_BRK;
          else if (in_data == SC_E1) begin
            w_state_nxt = ST_SKIP;
            w_skip_nxt  = SKIP_W'(PAUSE_SKIP);
          end else                   w_make = 1'b1;
        end
        ST_EXT: begin
          if (in_data == SC_F0) w_state_nxt = ST_EXT_BRK;
          else begin
            w_make      = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end
        ST_BRK, ST_EXT_BRK: begin
          w_break     = 1'b1;
          w_state_nxt = ST_IDLE;
        end
        ST_SKIP: begin
          w_skip_nxt = r_skip_cnt - SKIP_W'(1);
          if (r_skip_cnt <= SKIP_W'(1)) w_state_nxt = ST_IDLE;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Shift keys only move the modifier bits; the held key alone owns keycode.
  always_comb begin
    w_keycode_nxt = keycode;
    w_event_nxt   = 1'b0;
    w_held_nxt    = r_held;
    w_lshift_nxt  = r_lshift;
    w_rshift_nxt  = r_rshift;
    if (w_make || w_break) begin
      if (!w_ext && in_data == SC_LSHIFT)      w_lshift_nxt = w_make;
      else if (!w_ext && in_data == SC_RSHIFT) w_rshift_nxt = w_make;
      else if (w_make) begin
        if (w_map_valid) begin
          w_keycode_nxt = w_map_code;
          w_held_nxt    = held_t'{ext: w_ext, scan: in_data};
          w_event_nxt   = 1'b1;
        end
      end else if (r_held == held_t'{ext: w_ext, scan: in_data}) begin
        w_keycode_nxt = '0;
        w_held_nxt    = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ready_q  <= 1'b1;
      r_skip_cnt <= '0;
      r_held     <= '0;
      r_lshift   <= 1'b0;
      r_rshift   <= 1'b0;
      keycode    <= '0;
      key_event  <= 1'b0;
      shift      <= 1'b0;
    end else begin
      r_ready_q  <= in_ready;
      r_skip_cnt <= w_skip_nxt;
      r_held     <= w_held_nxt;
      r_lshift   <= w_lshift_nxt;
      r_rshift   <= w_rshift_nxt;
      keycode    <= w_keycode_nxt;
      key_event  <= w_event_nxt;
      shift      <= w_lshift_nxt | w_rshift_nxt;
    end
  end

endmodule

// File: tb/tb_ps2_keyboard_decoder.sv
// Directed bench for ps2_keyboard_decoder with a table-driven keyboard model checked every cycle.
module tb_ps2_keyboard_decoder;

  localparam int unsigned SKIP = 7;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  in_data;
  logic        in_ready;
  logic [15:0] keycode;
  logic        key_event;
  logic        shift;

  always #5 clk = ~clk;

  ps2_keyboard_decoder #(.PAUSE_SKIP(SKIP)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .keycode   (keycode),
    .key_event (key_event),
    .shift     (shift)
  );

  int unsigned map_lo[int];
  int unsigned map_hi[int];
  int unsigned map_ext[int];

  logic [15:0] m_key;
  logic        m_event;
  logic        m_ls;
  logic        m_rs;
  logic        m_ext;
  logic        m_brk;
  logic        m_held_v;
  logic        m_held_ext;
  logic [7:0]  m_held_scan;
  int          m_skip;
  int          sent_cnt = 0;
  int          done_cnt = 0;

  int total = 0;
  int bad   = 0;
  int ev_cnt = 0;
  int ev0;

  function automatic int unsigned lookup(input logic ext, input logic [7:0] sc, input logic sh);
    int k;
    k = int'(sc);
    if (ext) return map_ext.exists(k) ? map_ext[k] : 0;
    if (!map_lo.exists(k)) return 0;
    return sh ? map_hi[k] : map_lo[k];
  endfunction

  task automatic key_action(input logic ext, input logic make, input logic [7:0] sc);
    int unsigned code;
    if (!ext && sc == 8'h12) m_ls = make;
    else if (!ext && sc == 8'h59) m_rs = make;
    else if (make) begin
      code = lookup(ext, sc, m_ls | m_rs);
      if (code != 0) begin
        m_key = 16'(code);
        m_held_v = 1'b1;
        m_held_ext = ext;
        m_held_scan = sc;
        m_event = 1'b1;
      end
    end else if (m_held_v && m_held_ext == ext && m_held_scan == sc) begin
      m_key = '0;
      m_held_v = 1'b0;
    end
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (m_skip > 0) m_skip--;
    else if (b == 8'hE1 && !m_ext && !m_brk) m_skip = int'(SKIP);
    else if (b == 8'hE0 && !m_ext && !m_brk) m_ext = 1'b1;
    else if (b == 8'hF0 && !m_brk) m_brk = 1'b1;
    else begin
      key_action(m_ext, !m_brk, b);
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endtask

  task automatic model_edge();
    m_event = 1'b0;
    if (reset) begin
      m_key = '0; m_ls = 1'b0; m_rs = 1'b0; m_ext = 1'b0; m_brk = 1'b0;
      m_held_v = 1'b0; m_held_ext = 1'b0; m_held_scan = '0; m_skip = 0;
      done_cnt = sent_cnt;
    end else if (done_cnt != sent_cnt) begin
      done_cnt = sent_cnt;
      model_byte(in_data);
    end
  endtask

  always @(posedge clk) model_edge();

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    chk("keycode", keycode, m_key);
    chk("key_event", 16'(key_event), 16'(m_event));
    chk("shift", 16'(shift), 16'(m_ls | m_rs));
    if (key_event === 1'b1) ev_cnt++;
  endtask

  task automatic send(input logic [7:0] b, input int hold = 3);
    in_data = b;
    in_ready = 1'b1;
    sent_cnt++;
    repeat (hold) tick();
    in_ready = 1'b0;
    repeat (2) tick();
  endtask

  task automatic build_tables();
    string       letters = "abcdefghijklmnopqrstuvwxyz";
    int unsigned lo_c[22] = '{49, 50, 51, 52, 53, 54, 55, 56, 57, 48, 96, 45, 61, 91, 93, 92,
                              59, 39, 44, 46, 47, 32};
    int unsigned hi_c[22] = '{33, 64, 35, 36, 37, 94, 38, 42, 40, 41, 126, 95, 43, 123, 125, 124,
                              58, 34, 60, 62, 63, 32};
    byte unsigned let_sc[26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                                 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                                 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    byte unsigned pr_sc[22] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46,
                                8'h45, 8'h0E, 8'h4E, 8'h55, 8'h54, 8'h5B, 8'h5D, 8'h4C, 8'h52,
                                8'h41, 8'h49, 8'h4A, 8'h29};
    byte unsigned fk_sc[12] = '{8'h05, 8'h06, 8'h04, 8'h0C, 8'h03, 8'h0B, 8'h83, 8'h0A, 8'h01,
                                8'h09, 8'h78, 8'h07};
    byte unsigned ex_sc[11] = '{8'h6B, 8'h75, 8'h74, 8'h72, 8'h6C, 8'h69, 8'h7D, 8'h7A, 8'h70,
                                8'h71, 8'h5A};
    int unsigned  ex_cd[11] = '{130, 131, 132, 133, 134, 135, 136, 137, 138, 139, 128};
    for (int i = 0; i < 26; i++) begin
      map_lo[int'(let_sc[i])] = int'(letters[i]);
      map_hi[int'(let_sc[i])] = int'(letters[i]) - 32;
    end
    for (int i = 0; i < 22; i++) begin
      map_lo[int'(pr_sc[i])] = lo_c[i];
      map_hi[int'(pr_sc[i])] = hi_c[i];
    end
    for (int i = 0; i < 12; i++) begin
      map_lo[int'(fk_sc[i])] = 141 + i;
      map_hi[int'(fk_sc[i])] = 141 + i;
    end
    map_lo['h5A] = 128; map_hi['h5A] = 128;
    map_lo['h66] = 129; map_hi['h66] = 129;
    map_lo['h76] = 140; map_hi['h76] = 140;
    for (int i = 0; i < 11; i++) map_ext[int'(ex_sc[i])] = ex_cd[i];
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    build_tables();
    reset = 1'b1;
    in_ready = 1'b1;
    in_data = 8'h1C;
    repeat (3) tick();
    reset = 1'b0;
    repeat (5) tick();
    chk("reset_keycode", keycode, 16'd0);
    chk("reset_no_event", 16'(ev_cnt), 16'd0);
    in_ready = 1'b0;
    repeat (2) tick();

    send(8'h1C);
    chk("a_make", keycode, 16'd97);
    send(8'hF0); send(8'h1C);
    chk("a_break", keycode, 16'd0);
    chk("a_one_pulse", 16'(ev_cnt), 16'd1);

    send(8'h12); send(8'h1C);
    chk("shift_A", keycode, 16'd65);
    chk("shift_on", 16'(shift), 16'd1);
    send(8'hF0); send(8'h1C);
    chk("A_break", keycode, 16'd0);
    send(8'hF0); send(8'h12);
    chk("shift_off", 16'(shift), 16'd0);
    send(8'h59); send(8'h16);
    chk("rshift_bang", keycode, 16'd33);
    send(8'h52);
    chk("rshift_dquote", keycode, 16'd34);
    send(8'hF0); send(8'h52); send(8'hF0); send(8'h16); send(8'hF0); send(8'h59);
    chk("rshift_off", 16'(shift), 16'd0);

    send(8'hE0); send(8'h75);
    chk("ext_up", keycode, 16'd131);
    send(8'hE0); send(8'hF0); send(8'h75);
    chk("ext_up_break", keycode, 16'd0);
    send(8'h1C);
    send(8'hE0); send(8'h12); send(8'hE0); send(8'h7C);
    chk("fake_shift", 16'(shift), 16'd0);
    chk("ext_unmapped", keycode, 16'd97);
    send(8'hF0); send(8'h1C);

    send(8'h1C); send(8'h32);
    chk("b_newer", keycode, 16'd98);
    send(8'hF0); send(8'h1C);
    chk("older_release", keycode, 16'd98);
    send(8'hF0); send(8'h32);
    chk("b_release", keycode, 16'd0);
    ev0 = ev_cnt;
    send(8'h1C); send(8'h1C); send(8'h1C);
    chk("typematic_pulses", 16'(ev_cnt - ev0), 16'd3);
    chk("typematic_key", keycode, 16'd97);
    send(8'hF0); send(8'h1C);

    send(8'h83);
    chk("f7", keycode, 16'd147);
    send(8'hE0); send(8'h5A);
    chk("kp_enter", keycode, 16'd128);
    send(8'h76);
    chk("esc", keycode, 16'd140);
    send(8'hF0); send(8'h76);
    send(8'hFA); send(8'hAA);
    chk("ack_bat_ignored", keycode, 16'd0);

    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
    chk("pause_skipped", keycode, 16'd0);
    send(8'h29);
    chk("space_after_pause", keycode, 16'd32);
    chk("pause_shift", 16'(shift), 16'd0);
    send(8'hF0); send(8'h29);

    send(8'h1C);
    send(8'hE0);
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    tick();
    chk("mid_reset", keycode, 16'd0);
    send(8'h6B);
    chk("6B_not_ext", keycode, 16'd0);

    ev0 = ev_cnt;
    send(8'h1C, 20);
    chk("long_ready_one_decode", 16'(ev_cnt - ev0), 16'd1);
    chk("long_ready_key", keycode, 16'd97);
    send(8'hF0); send(8'h1C);
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ps2_keyboard_decoder.md
Name: ps2_keyboard_decoder

Overview:
Sits directly downstream of the PS/2 byte receiver and consumes its 8-bit scan-code bytes (Set 2).
- Tracks E0/F0/E1 prefixes and shift state.
- Drives the 16-bit Hack keyboard register value: the code of the currently held key, or 0 when no key is held.
- The memory-mapped KBD register of the CPU reads keycode directly.

Parameters:
PAUSE_SKIP, 7, number of bytes discarded after an E1 prefix (Pause sequence tail)

Ports:
clk  input  1  system clock; all state is updated on its rising edge
reset  input  1  synchronous, active-high reset
in_data  input  8  scan-code byte from the receiver; stable while in_ready is high
in_ready  input  1  receiver ready level; stays high until the next frame starts, so it is not a single-cycle pulse
keycode  output  16  Hack key code of the held key, 0 if none
key_event  output  1  one-cycle pulse whenever keycode is written by a make code (including typematic repeat)
shift  output  1  current shift state (left or right shift held)

Behaviour:
- Reset values: keycode=0, key_event=0, shift=0, state=IDLE, held={ext=0,scan=0}, ready_q=1, skip_cnt=0.
- ready_q=1 at reset means a ready level already high at reset release is not consumed.
- Byte strobe: stb = in_ready & ~ready_q; ready_q <= in_ready every cycle.
- All decoding happens on the edge at which stb=1. keycode and key_event update on that same edge (latency 1 edge from first sample of in_ready high).
- key_event is high for exactly that one cycle.
- States: IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 F0 seen), SKIP.
- Transitions on stb:
  - IDLE: E0->EXT; F0->BRK; E1->SKIP with skip_cnt=PAUSE_SKIP; other->make(ext=0), stay IDLE.
  - EXT: F0->EXT_BRK; other->make(ext=1), ->IDLE.
  - BRK: any->break(ext=0), ->IDLE.
  - EXT_BRK: any->break(ext=1), ->IDLE.
  - SKIP: skip_cnt decrements; byte ignored; at skip_cnt==1 ->IDLE.
- Modifiers:
  - Make/break of 0x12 or 0x59 with ext=0 sets/clears shift.
  - shift=1 while either key is held; the two shift keys are tracked separately.
  - Modifiers never touch keycode or held.
  - E0 12 and E0 59 (fake shifts) are ignored.
- Make of a mapped key: keycode <= lookup(ext,scan,shift); held <= {ext,scan}; key_event=1.
- Make of an unmapped key: ignored, with no change to keycode, held or key_event.
- Break:
  - If {ext,scan}==held: keycode <= 0 and held cleared.
  - Otherwise no change. Releasing an older key while a newer one is held keeps the newer keycode.
- A shift change while a key is held does not re-evaluate keycode.
- Bytes 0xAA (BAT OK), 0xFA (ACK), 0xFE and 0x00/0xFF (errors) in IDLE are ignored.
- Mapping, Hack codes:
  - Printable keys (US layout) give ASCII.
    - Letters: lowercase unshifted, uppercase when shifted.
    - Digits: shifted gives !@#$%^&*().
    - Punctuation: ` - = [ ] \ ; ' , . / with their shifted pairs.
    - Space 0x29=32.
  - Enter 5A=128, Backspace 66=129, Esc 76=140.
  - Extended keys:
    - E0 6B=130 (left), E0 75=131 (up), E0 74=132 (right), E0 72=133 (down).
    - E0 6C=134 (home), E0 69=135 (end), E0 7D=136 (page up), E0 7A=137 (page down).
    - E0 70=138 (insert), E0 71=139 (delete).
  - Function keys F1..F12 = 141..152, scan codes 05 06 04 0C 03 0B 83 0A 01 09 78 07.
  - Keypad Enter E0 5A=128.
- Reset mid-sequence, e.g. after E0 or inside SKIP: all state returns to reset values on that edge. Reset wins over a simultaneous stb.

Decomposition:
- Shared package (ps2_pkg):
  - prefix constants E0/F0/E1 and shift scan codes;
  - Hack special-key codes 128..152;
  - state encoding.
- Sub-module scancode_to_hack: purely combinational lookup.
  - Inputs: {ext, scan[7:0], shift}. Outputs: code[15:0], valid.
  - It holds the full table, so the decoder FSM stays small.

Test Plan:
- Reset with in_ready held high, then no new byte -> keycode=0, no key_event. Byte 1C then F0 1C -> keycode=97 with one key_event pulse, then 0.
- 12, 1C, F0 1C, F0 12 -> shift=1, keycode=65 then 0, shift=0. Also 59, 16 -> keycode=33 ('!').
- E0 75, E0 F0 75 -> keycode=131 then 0. Also E0 12 E0 7C -> shift stays 0, keycode unchanged (unmapped).
- 1C, 32, F0 1C -> keycode 97, then 98, stays 98. F0 32 -> 0. Repeated 1C 1C 1C -> keycode 97, three key_event pulses.
- Pause: E1 14 77 E1 F0 14 F0 77, then 29 -> only the 29 is decoded, keycode=32, shift=0.
- E0 then reset then 6B -> keycode=0 after reset. The 6B is decoded non-extended and unmapped, so keycode stays 0. in_ready held high for 20 cycles -> exactly one decode.
